// File: rtl/window_3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator and the 3x3 filters fed by it.
package window_3x3_gen_pkg;

    localparam int PIXEL_WIDTH    = 8;
    localparam int WIN_SIZE       = 3;
    localparam int ROW_WIDTH      = PIXEL_WIDTH * WIN_SIZE;
    localparam int P_LATENCY      = 3;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic [ROW_WIDTH-1:0]   row_t;

endpackage

// File: rtl/window_3x3_gen_line_buffer_ram.sv
// Single-clock simple dual-port RAM, synchronous read, read-before-write.
module line_buffer_ram #(
    parameter int P_DEPTH      = 640,
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [P_ADDR_WIDTH-1:0] waddr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    input  logic [P_ADDR_WIDTH-1:0] raddr,
    output logic [P_DATA_WIDTH-1:0] rdata
);

    logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];

    // No reset: stale contents are masked downstream by the line counter.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus three 3-deep
// row shift registers, zero-padded at the top and left image borders.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int P_IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int P_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_h_sync,
    input  logic                   i_v_sync,
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    output logic                   o_h_sync,
    output logic                   o_v_sync,
    output logic [ROW_WIDTH-1:0]   o_raws_col1,
    output logic [ROW_WIDTH-1:0]   o_raws_col2,
    output logic [ROW_WIDTH-1:0]   o_raws_col3
);

    // One extra bit so the column counter can hold P_IMG_WIDTH itself.
    localparam int            CW    = P_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] IMG_W = CW'(P_IMG_WIDTH);
    localparam int            KEEP  = ROW_WIDTH - PIXEL_WIDTH;

    logic                    act_in;
    logic [P_LATENCY-1:0]    act_pipe;
    logic [P_LATENCY-1:0]    v_pipe;
    pixel_t                  s1_pixel;
    pixel_t                  s2_pixel;
    logic [CW-1:0]           col_cnt;
    logic [P_ADDR_WIDTH-1:0] s2_addr;
    logic                    s2_in_range;
    logic [1:0]              line_cnt;
    pixel_t                  lb0_rdata;
    pixel_t                  lb1_rdata;
    pixel_t                  tap_y1;
    pixel_t                  tap_y2;
    row_t                    row_y0;
    row_t                    row_y1;
    row_t                    row_y2;

    assign act_in = i_h_sync & i_v_sync;

    // Taps beyond the buffered width, or from lines not yet seen in this frame, read as 0.
    assign tap_y1 = (s2_in_range && line_cnt != 2'd0) ? lb0_rdata : '0;
    assign tap_y2 = (s2_in_range && line_cnt == 2'd2) ? lb1_rdata : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_pipe    <= '0;
            v_pipe      <= '0;
            s1_pixel    <= '0;
            s2_pixel    <= '0;
            col_cnt     <= '0;
            s2_addr     <= '0;
            s2_in_range <= 1'b0;
            line_cnt    <= 2'd0;
            row_y0      <= '0;
            row_y1      <= '0;
            row_y2      <= '0;
        end else begin
            act_pipe    <= {act_pipe[P_LATENCY-2:0], act_in};
            v_pipe      <= {v_pipe[P_LATENCY-2:0], i_v_sync};
            s1_pixel    <= i_pixel;
            s2_pixel    <= s1_pixel;
            s2_addr     <= col_cnt[P_ADDR_WIDTH-1:0];
            s2_in_range <= (col_cnt < IMG_W);

            if (!act_pipe[0]) begin
                col_cnt <= '0;
            end else if (col_cnt < IMG_W) begin
                col_cnt <= col_cnt + 1'b1;
            end

            // Frame clear takes priority over the end-of-line increment.
            if (!v_pipe[0]) begin
                line_cnt <= 2'd0;
            end else if (act_pipe[1] && !act_pipe[0] && line_cnt != 2'd2) begin
                line_cnt <= line_cnt + 2'd1;
            end

            // Rows are held at zero between lines, which pads the left border.
            if (act_pipe[1]) begin
                row_y0 <= {row_y0[KEEP-1:0], s2_pixel};
                row_y1 <= {row_y1[KEEP-1:0], tap_y1};
                row_y2 <= {row_y2[KEEP-1:0], tap_y2};
            end else begin
                row_y0 <= '0;
                row_y1 <= '0;
                row_y2 <= '0;
            end
        end
    end

    line_buffer_ram #(
        .P_DEPTH     (P_IMG_WIDTH),
        .P_ADDR_WIDTH(P_ADDR_WIDTH),
        .P_DATA_WIDTH(PIXEL_WIDTH)
    ) lb0 (
        .clk  (i_clk),
        .we   (act_pipe[1] & s2_in_range),
        .waddr(s2_addr),
        .wdata(s2_pixel),
        .raddr(col_cnt[P_ADDR_WIDTH-1:0]),
        .rdata(lb0_rdata)
    );

    // lb1 takes the line leaving lb0, read at the same column before it is overwritten.
    line_buffer_ram #(
        .P_DEPTH     (P_IMG_WIDTH),
        .P_ADDR_WIDTH(P_ADDR_WIDTH),
        .P_DATA_WIDTH(PIXEL_WIDTH)
    ) lb1 (
        .clk  (i_clk),
        .we   (act_pipe[1] & s2_in_range),
        .waddr(s2_addr),
        .wdata(lb0_rdata),
        .raddr(col_cnt[P_ADDR_WIDTH-1:0]),
        .rdata(lb1_rdata)
    );

    assign o_h_sync    = act_pipe[P_LATENCY-1];
    assign o_v_sync    = v_pipe[P_LATENCY-1];
    assign o_raws_col1 = row_y2;
    assign o_raws_col2 = row_y1;
    assign o_raws_col3 = row_y0;

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator placed directly upstream of the 3x3 mean filter.
- Accepts one 8-bit infrared pixel per clock in raster order, framed by h_sync/v_sync.
- Buffers the two previous lines in on-chip RAM and emits three 24-bit row vectors plus delayed syncs, matching the mean-filter input interface exactly.
- Out-of-image neighbours (top two lines, left two columns) are zero-padded.

Parameters:
- P_IMG_WIDTH, 640, maximum active pixels per line; line-buffer depth.
- P_ADDR_WIDTH, 10, column counter / RAM address width; must satisfy 2**P_ADDR_WIDTH >= P_IMG_WIDTH.
- P_LATENCY, 3, fixed input-to-output delay in clocks; informational only, not overridable.

Ports:
- i_clk  input  1  pixel clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_h_sync  input  1  line-active qualifier.
- i_v_sync  input  1  frame-active qualifier.
- i_pixel  input  8  pixel data; valid when i_h_sync & i_v_sync.
- o_h_sync  output  1  i_h_sync & i_v_sync delayed 3 clocks.
- o_v_sync  output  1  i_v_sync delayed 3 clocks.
- o_raws_col1  output  24  window row y-2 (oldest line).
- o_raws_col2  output  24  window row y-1.
- o_raws_col3  output  24  window row y (current line).

Behaviour:
- Interface: one clock, i_clk; reset i_rst_n is asynchronous, active-low. All outputs are registered and reset to 0.
- Active = i_h_sync & i_v_sync, registered at input stage 1.
- Row vector byte order in each o_raws_colN:
  - [23:16] = column x-2
  - [15:8] = column x-1
  - [7:0] = column x (newest)
- Pipeline, exactly 3 clocks from input to output:
  - S1: register pixel and syncs; issue synchronous RAM reads at col_cnt.
  - S2: RAM data valid. Write lb0[col]=pixel and lb1[col]=lb0 read data (read-before-write, same address).
  - S3: shift {lb1_data, lb0_data, pixel} into three 3-deep shift registers; drive outputs.
- col_cnt:
  - Increments on each active pixel.
  - Clears on the falling edge of active and while v_sync is low.
  - Saturates at P_IMG_WIDTH. Pixels at col >= P_IMG_WIDTH are not written to RAM, and their row1/row2 taps read as 0.
- line_cnt:
  - Increments on each falling edge of active with v_sync high; saturates at 2.
  - Clears while v_sync is low.
- Row masking:
  - Row y-1 data is forced to 0 when line_cnt < 1.
  - Row y-2 data is forced to 0 when line_cnt < 2.
  - RAM is never cleared; stale contents are masked by line_cnt.
- Column masking: the shift registers clear at the rising edge of active, so the first pixel of a line outputs [23:8]=0 and the second outputs [23:16]=0.
- While the delayed active is low, all o_raws_colN = 0.
- Lines shorter than P_IMG_WIDTH: only written entries are meaningful. The tail of the next line reads stale data; this is acceptable and documented.
- Simultaneous falling of h_sync and v_sync: line_cnt clears; v_sync clear wins over increment.
- Reset mid-frame: all counters, shift registers and pipeline registers clear. The next frame must start with v_sync low for at least 1 clock.

Decomposition:
- Shared package/header holds:
  - pixel width constant (8)
  - window size constant (3)
  - P_LATENCY
  - default P_IMG_WIDTH and P_ADDR_WIDTH, shared with mean_filter_3X3 and later 3x3 filters.
- One sub-module: line_buffer_ram.
  - Single-clock simple dual-port, synchronous read, read-before-write, parameterised depth and width.
  - Instantiated twice (lb0, lb1).

Test Plan (P_IMG_WIDTH=4, pixel value = 16*line + col + 1):
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0. Release -> outputs stay 0 until the first active pixel plus 3 clocks.
- Frame line 0, pixels 1,2,3,4 -> o_raws_col3 = 0x000001, 0x000102, 0x010203, 0x020304 at cycles t+3..t+6. col1 and col2 = 0. o_h_sync high for exactly 4 clocks.
- Line 2, col 2 (pixel 0x23) -> col1=0x010203, col2=0x111213, col3=0x212223. Feeding this into mean_filter_3X3 yields 0x12.
- Overlong line of 6 pixels on line 2 -> cols 4-5 show col1/col2 taps 0. Line 3 rows are unaffected at cols 0-3.
- v_sync drop mid-line 1, then a new frame -> first line of the new frame has col1=col2=0 despite stale RAM.
- Assert i_rst_n=0 during line 2 -> outputs 0 asynchronously. The next frame behaves identically to the first frame.
